// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the SRAM primary-port arbiter: FSM states, owner encoding
// and the word-width derivation used by the top level.
package sram_port_arbiter_pkg;

    localparam int DEFAULT_BYTE_COUNT   = 4;
    localparam int DEFAULT_ADDRESS_SIZE = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

    function automatic int word_size(input int byte_count);
        return 8 * byte_count;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational one-hot grant, indexed by owner.
// On contention the requester that did not win last time is granted.
module rr_arbiter_2
    import sram_port_arbiter_pkg::*;
(
    input  logic [1:0] valid_i,
    input  owner_e     last_grant_i,
    input  logic       enable_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            if (valid_i == 2'b11) begin
                grant_o = (last_grant_i == OWNER_B) ? 2'b01 : 2'b10;
            end else begin
                grant_o = valid_i;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the SRAM primary port between requesters A and B, one transaction at
// a time, turning the SRAM's registered-input / negedge-output timing into done pulses.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter  int BYTE_COUNT   = DEFAULT_BYTE_COUNT,
    parameter  int ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE,
    localparam int WORD_SIZE    = word_size(BYTE_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic                    a_we,
    input  logic [BYTE_COUNT-1:0]   a_mask,
    input  logic [ADDRESS_SIZE-1:0] a_addr,
    input  logic [WORD_SIZE-1:0]    a_wdata,
    output logic                    a_done,
    output logic [WORD_SIZE-1:0]    a_rdata,

    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic                    b_we,
    input  logic [BYTE_COUNT-1:0]   b_mask,
    input  logic [ADDRESS_SIZE-1:0] b_addr,
    input  logic [WORD_SIZE-1:0]    b_wdata,
    output logic                    b_done,
    output logic [WORD_SIZE-1:0]    b_rdata,

    output logic                    sram_select,
    output logic                    sram_write_enable,
    output logic [BYTE_COUNT-1:0]   sram_write_mask,
    output logic [ADDRESS_SIZE-1:0] sram_address,
    output logic [WORD_SIZE-1:0]    sram_data_write,
    input  logic [WORD_SIZE-1:0]    sram_data_read
);

    state_e state_q, state_d;
    owner_e owner_q, owner_d;
    owner_e last_grant_q, last_grant_d;

    // The sram_* registers double as the command registers.
    logic                    sram_select_q;
    logic                    sram_write_enable_q;
    logic [BYTE_COUNT-1:0]   sram_write_mask_q;
    logic [ADDRESS_SIZE-1:0] sram_address_q;
    logic [WORD_SIZE-1:0]    sram_data_write_q;
    logic [WORD_SIZE-1:0]    a_rdata_q;
    logic [WORD_SIZE-1:0]    b_rdata_q;

    logic [1:0]              grant;
    logic                    granted;
    logic                    sel_we;
    logic [BYTE_COUNT-1:0]   sel_mask;
    logic [ADDRESS_SIZE-1:0] sel_addr;
    logic [WORD_SIZE-1:0]    sel_wdata;

    rr_arbiter_2 u_rr_arbiter_2 (
        .valid_i      ({b_valid, a_valid}),
        .last_grant_i (last_grant_q),
        .enable_i     (state_q == IDLE),
        .grant_o      (grant)
    );

    assign granted   = |grant;
    assign sel_we    = grant[OWNER_B] ? b_we    : a_we;
    assign sel_mask  = grant[OWNER_B] ? b_mask  : a_mask;
    assign sel_addr  = grant[OWNER_B] ? b_addr  : a_addr;
    assign sel_wdata = grant[OWNER_B] ? b_wdata : a_wdata;

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (granted) begin
                    owner_d      = grant[OWNER_B] ? OWNER_B : OWNER_A;
                    last_grant_d = owner_d;
                    state_d      = ISSUE;
                end
            end
            ISSUE:   state_d = sram_write_enable_q ? DONE : WAIT;
            WAIT:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q             <= IDLE;
            owner_q             <= OWNER_A;
            last_grant_q        <= OWNER_B;
            sram_select_q       <= 1'b0;
            sram_write_enable_q <= 1'b0;
            sram_write_mask_q   <= '0;
            sram_address_q      <= '0;
            sram_data_write_q   <= '0;
            a_rdata_q           <= '0;
            b_rdata_q           <= '0;
        end else begin
            state_q             <= state_d;
            owner_q             <= owner_d;
            last_grant_q        <= last_grant_d;
            // Select and write enable are high only for the ISSUE cycle after a grant.
            sram_select_q       <= granted;
            sram_write_enable_q <= granted & sel_we;
            if (granted) begin
                sram_write_mask_q <= sel_mask;
                sram_address_q    <= sel_addr;
                sram_data_write_q <= sel_wdata;
            end
            // SRAM output settled on the negedge inside WAIT.
            if (state_q == WAIT) begin
                if (owner_q == OWNER_A) begin
                    a_rdata_q <= sram_data_read;
                end else begin
                    b_rdata_q <= sram_data_read;
                end
            end
        end
    end

    assign a_ready           = grant[OWNER_A];
    assign b_ready           = grant[OWNER_B];
    assign a_done            = (state_q == DONE) && (owner_q == OWNER_A);
    assign b_done            = (state_q == DONE) && (owner_q == OWNER_B);
    assign a_rdata           = a_rdata_q;
    assign b_rdata           = b_rdata_q;
    assign sram_select       = sram_select_q;
    assign sram_write_enable = sram_write_enable_q;
    assign sram_write_mask   = sram_write_mask_q;
    assign sram_address      = sram_address_q;
    assign sram_data_write   = sram_data_write_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: transaction-level reference model,
// behavioural SRAM with negedge read output, directed and random traffic.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_valid = 1'b0, a_we = 1'b0;
    logic [3:0]  a_mask = '0;
    logic [8:0]  a_addr = '0;
    logic [31:0] a_wdata = '0;
    logic        b_valid = 1'b0, b_we = 1'b0;
    logic [3:0]  b_mask = '0;
    logic [8:0]  b_addr = '0;
    logic [31:0] b_wdata = '0;
    logic        a_ready, a_done, b_ready, b_done;
    logic [31:0] a_rdata, b_rdata;
    logic        sram_select, sram_write_enable;
    logic [3:0]  sram_write_mask;
    logic [8:0]  sram_address;
    logic [31:0] sram_data_write;
    logic [31:0] sram_data_read = '0;

    sram_port_arbiter #(.BYTE_COUNT(4), .ADDRESS_SIZE(9)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_mask(a_mask),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_done(a_done), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_mask(b_mask),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_done(b_done), .b_rdata(b_rdata),
        .sram_select(sram_select), .sram_write_enable(sram_write_enable),
        .sram_write_mask(sram_write_mask), .sram_address(sram_address),
        .sram_data_write(sram_data_write), .sram_data_read(sram_data_read)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural SRAM: captures on posedge while selected, read data appears on the next negedge.
    logic [31:0] mem [512];
    logic        rd_pend = 1'b0;
    logic [8:0]  rd_addr = '0;
    initial for (int i = 0; i < 512; i++) mem[i] = '0;

    always @(posedge clk) begin
        rd_pend <= sram_select && !sram_write_enable;
        if (sram_select) begin
            rd_addr <= sram_address;
            if (sram_write_enable)
                for (int i = 0; i < 4; i++)
                    if (sram_write_mask[i]) mem[sram_address][8*i +: 8] <= sram_data_write[8*i +: 8];
        end
    end
    always @(negedge clk) sram_data_read <= rd_pend ? mem[rd_addr] : $urandom;

    // Reference model state (transaction level).
    typedef struct { bit owner; logic [31:0] rdata; int due; } done_t;
    typedef struct { bit we; logic [3:0] mask; logic [8:0] addr; logic [31:0] data; int due; } iss_t;
    done_t       dq[$];
    iss_t        sq[$];
    bit          grant_log[$];
    int          acc_cyc_a[$];
    logic [31:0] ref_mem [512];
    logic [31:0] ref_rdata [2];
    bit          ref_last = 1'b1;
    int          free_cyc = 0;
    int          a_acc_cnt = 0, b_acc_cnt = 0;
    int          a_seen = 0, b_seen = 0;
    initial for (int i = 0; i < 512; i++) ref_mem[i] = '0;
    initial begin ref_rdata[0] = '0; ref_rdata[1] = '0; end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    always @(negedge clk) begin : monitor
        done_t       e;
        iss_t        s;
        logic [1:0]  exp_done;
        logic [1:0]  exp_g;
        bit          w, cwe;
        logic [3:0]  cm;
        logic [8:0]  ca;
        logic [31:0] cd;
        if (!rst) begin
            dq.delete(); sq.delete(); grant_log.delete(); acc_cyc_a.delete();
            ref_last = 1'b1; ref_rdata[0] = '0; ref_rdata[1] = '0; free_cyc = 0;
        end else begin
            exp_done = 2'b00;
            if (dq.size() != 0 && dq[0].due == cyc) begin
                e = dq.pop_front();
                exp_done[e.owner] = 1'b1;
                if (e.owner) check("b_rdata", b_rdata, e.rdata);
                else         check("a_rdata", a_rdata, e.rdata);
            end
            check("done", {b_done, a_done}, exp_done);
            if (sq.size() != 0 && sq[0].due == cyc) begin
                s = sq.pop_front();
                check("sram_select", sram_select, 1);
                check("sram_we", sram_write_enable, s.we);
                check("sram_addr", sram_address, s.addr);
                check("sram_mask", sram_write_mask, s.mask);
                if (s.we) check("sram_wdata", sram_data_write, s.data);
            end else begin
                check("sram_idle", {sram_select, sram_write_enable}, 0);
            end
            exp_g = 2'b00;
            if (cyc >= free_cyc && (a_valid || b_valid)) begin
                if (a_valid && b_valid) exp_g = ref_last ? 2'b01 : 2'b10;
                else                    exp_g = {b_valid, a_valid};
            end
            check("ready", {b_ready, a_ready}, exp_g);
            if (exp_g != 2'b00) begin
                w   = exp_g[1];
                cwe = w ? b_we : a_we;      cm = w ? b_mask : a_mask;
                ca  = w ? b_addr : a_addr;  cd = w ? b_wdata : a_wdata;
                ref_last = w;
                grant_log.push_back(w);
                if (!w) acc_cyc_a.push_back(cyc);
                sq.push_back('{we: cwe, mask: cm, addr: ca, data: cd, due: cyc + 1});
                if (cwe) begin
                    ref_mem[ca] = merge(ref_mem[ca], cd, cm);
                    dq.push_back('{owner: w, rdata: ref_rdata[w], due: cyc + 2});
                    free_cyc = cyc + 3;
                end else begin
                    ref_rdata[w] = ref_mem[ca];
                    dq.push_back('{owner: w, rdata: ref_rdata[w], due: cyc + 3});
                    free_cyc = cyc + 4;
                end
            end
            if (a_valid && a_ready) a_acc_cnt++;
            if (b_valid && b_ready) b_acc_cnt++;
        end
    end

    task automatic set_cmd(input bit r, input bit v, input bit we, input logic [3:0] m,
                           input logic [8:0] ad, input logic [31:0] d);
        if (!r) begin a_valid = v; a_we = we; a_mask = m; a_addr = ad; a_wdata = d; end
        else    begin b_valid = v; b_we = we; b_mask = m; b_addr = ad; b_wdata = d; end
    endtask

    task automatic set_rand(input bit r, input bit reads_only);
        set_cmd(r, 1'b1, reads_only ? 1'b0 : 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                9'($urandom_range(0, 15)), $urandom);
    endtask

    task automatic sync_seen();
        a_seen = a_acc_cnt;
        b_seen = b_acc_cnt;
    endtask

    task automatic issue(input bit r, input bit we, input logic [3:0] m, input logic [8:0] ad, input logic [31:0] d);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        sync_seen();
        set_cmd(r, 1'b1, we, m, ad, d);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); #1;
            got = r ? (b_acc_cnt != b_seen) : (a_acc_cnt != a_seen);
        end
        check("accept_in_time", got, 1);
        @(posedge clk); #1;
        set_cmd(r, 1'b0, we, m, ad, d);
        sync_seen();
    endtask

    // Modes: 0 idle, 1 valid held with fresh random commands, 2 random with gaps/withdrawals, 3 reads held.
    task automatic run(input int n, input int ma, input int mb);
        int  m;
        bit  acc, v;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            for (int r = 0; r < 2; r++) begin
                m   = r ? mb : ma;
                acc = r ? (b_acc_cnt != b_seen) : (a_acc_cnt != a_seen);
                v   = r ? b_valid : a_valid;
                if (m == 0) set_cmd(1'(r), 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
                else if (acc || !v) begin
                    if (m == 2 && $urandom_range(0, 2) == 0) set_cmd(1'(r), 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
                    else set_rand(1'(r), m == 3);
                end else if (m == 2 && $urandom_range(0, 7) == 0) begin
                    set_cmd(1'(r), 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
                end
            end
            sync_seen();
        end
    endtask

    task automatic drain();
        @(posedge clk); #1;
        set_cmd(1'b0, 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
        set_cmd(1'b1, 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
        sync_seen();
        repeat (6) @(posedge clk);
    endtask

    task automatic reset_check();
        check("rst_ready", {b_ready, a_ready}, 0);
        check("rst_done", {b_done, a_done}, 0);
        check("rst_a_rdata", a_rdata, 0);
        check("rst_b_rdata", b_rdata, 0);
        check("rst_sram_ctrl", {sram_select, sram_write_enable, sram_write_mask}, 0);
        check("rst_sram_addr", sram_address, 0);
        check("rst_sram_wdata", sram_data_write, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        set_cmd(1'b0, 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
        set_cmd(1'b1, 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_check();
        @(posedge clk); #1;
        rst = 1'b1;
        sync_seen();
    endtask

    task automatic contention(input string tag);
        run(18, 1, 1);
        drain();
        check({tag, "_grants"}, 64'(grant_log.size() >= 4), 1);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check({tag, "_order"}, grant_log[i], i % 2);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int start;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_check();
        @(posedge clk); #1;
        rst = 1'b1;

        issue(1'b0, 1'b1, 4'hF, 9'h005, 32'hDEADBEEF);
        issue(1'b0, 1'b0, 4'hF, 9'h005, 32'h0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t2_a_rdata", a_rdata, 32'hDEADBEEF);

        issue(1'b1, 1'b1, 4'h3, 9'h005, 32'h12345678);
        issue(1'b0, 1'b0, 4'hF, 9'h005, 32'h0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t3_a_rdata", a_rdata, 32'hDEAD5678);
        check("t3_b_rdata_kept", b_rdata, 32'h0);

        do_reset();
        contention("t4");

        issue(1'b0, 1'b0, 4'hF, 9'h005, 32'h0);
        do_reset();
        contention("t5");

        start = acc_cyc_a.size();
        run(21, 3, 0);
        drain();
        check("t6_count", 64'(acc_cyc_a.size() - start >= 4), 1);
        for (int i = start + 1; i < acc_cyc_a.size(); i++)
            check("t6_spacing", acc_cyc_a[i] - acc_cyc_a[i-1], 4);

        run(1500, 2, 2);
        run(300, 1, 2);
        drain();
        check("dq_empty", dq.size(), 0);
        check("sq_empty", sq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
